// File: rtl/vga_frame_buffer.sv
// 160x120 RGB332 frame buffer scaled 4x4 onto a 640x480 VGA raster, with a host pixel write
// port and a whole-buffer clear engine. Optional colour-bar test pattern under VGA_PATTERN_EN.
module vga_frame_buffer #(
    parameter int unsigned FB_W       = 160,
    parameter int unsigned FB_H       = 120,
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [8:0]  row_i,
    input  logic [9:0]  column_i,
    output logic [15:0] rgb_o,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [7:0]  wr_x_i,
    input  logic [6:0]  wr_y_i,
    input  logic [7:0]  wr_data_i,
    output logic        wr_err_o,
    input  logic        clear_i,
    input  logic [7:0]  clear_color_i,
    output logic        busy_o,
    input  logic        pattern_i
);

    localparam int unsigned DEPTH = FB_W * FB_H;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SCR_W = FB_W << SCALE_LOG2;
    localparam int unsigned SCR_H = FB_H << SCALE_LOG2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    // Linear address y*FB_W + x; the default width reduces to two shifts and an add.
    function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] x, input logic [AW-1:0] y);
        if (FB_W == 160) begin
            return (y << 7) + (y << 5) + x;
        end else begin
            return AW'(y * FB_W) + x;
        end
    endfunction

    function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
        return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
    endfunction

    logic [7:0]    mem [DEPTH];
    logic [7:0]    pix_q;
    logic          range_q;

    state_e        state_q;
    logic          busy_q;
    logic          wr_err_q;
    logic [AW-1:0] clr_addr_q;
    logic [7:0]    clr_color_q;

    logic [AW-1:0] rd_x;
    logic [AW-1:0] rd_y;
    logic [AW-1:0] rd_addr;
    logic          rd_in_range;

    logic          wr_fire;
    logic          wr_in_range;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // ---------------------------------------------------------------- read path
    assign rd_x        = AW'(column_i >> SCALE_LOG2);
    assign rd_y        = AW'(row_i >> SCALE_LOG2);
    assign rd_addr     = lin_addr(rd_x, rd_y);
    assign rd_in_range = (32'(row_i) < SCR_H) && (32'(column_i) < SCR_W);

    // ---------------------------------------------------------------- write path
    assign wr_ready_o  = (state_q == StIdle);
    assign wr_fire     = wr_valid_i && wr_ready_o;
    assign wr_in_range = (32'(wr_x_i) < FB_W) && (32'(wr_y_i) < FB_H);
    assign wr_err_o    = wr_err_q;
    assign busy_o      = busy_q;

    // The clear engine owns the single RAM write port; host writes only land in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = lin_addr(AW'(wr_x_i), AW'(wr_y_i));
        mem_wdata = wr_data_i;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = clr_color_q;
        end else if (wr_fire && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    // Block RAM: contents not reset; same-address read during write returns old data.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_in_range) begin
            pix_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            range_q <= 1'b0;
        end else begin
            range_q <= rd_in_range;
        end
    end

    // ---------------------------------------------------------------- clear FSM
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            wr_err_q <= wr_fire && !wr_in_range;
            case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        clr_color_q <= clear_color_i;
                        clr_addr_q  <= '0;
                        state_q     <= StClear;
                        busy_q      <= 1'b1;
                    end
                end
                StClear: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- output
`ifdef VGA_PATTERN_EN
    localparam int unsigned BAR_W = SCR_W / 8;

    logic       pat_q;
    logic [2:0] bar_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pat_q <= 1'b0;
            bar_q <= '0;
        end else begin
            pat_q <= pattern_i;
            bar_q <= 3'(32'(column_i) / BAR_W);
        end
    end

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        rgb_o = 16'h0000;
        if (range_q) begin
            rgb_o = pat_q ? bar_color(bar_q) : rgb332_to_565(pix_q);
        end
    end
`else
    logic unused_pattern;
    assign unused_pattern = pattern_i;

    always_comb begin
        rgb_o = 16'h0000;
        if (range_q) begin
            rgb_o = rgb332_to_565(pix_q);
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed self-checking bench for vga_frame_buffer: reset, colour expansion, range edges,
// write errors, clear timing with stalled writes, and reset during a clear.
module tb_vga_frame_buffer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [8:0]  row_i;
    logic [9:0]  column_i;
    logic [15:0] rgb_o;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  wr_x_i;
    logic [6:0]  wr_y_i;
    logic [7:0]  wr_data_i;
    logic        wr_err_o;
    logic        clear_i;
    logic [7:0]  clear_color_i;
    logic        busy_o;
    logic        pattern_i;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clk_i = ~clk_i;

    vga_frame_buffer dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .row_i         (row_i),
        .column_i      (column_i),
        .rgb_o         (rgb_o),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_x_i        (wr_x_i),
        .wr_y_i        (wr_y_i),
        .wr_data_i     (wr_data_i),
        .wr_err_o      (wr_err_o),
        .clear_i       (clear_i),
        .clear_color_i (clear_color_i),
        .busy_o        (busy_o),
        .pattern_i     (pattern_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Request a screen position; the colour must appear one edge later.
    task automatic read_px(input string tag, input int r, input int c, input logic [15:0] exp);
        row_i    = 9'(r);
        column_i = 10'(c);
        tick();
        check(tag, 32'(rgb_o), 32'(exp));
    endtask

    task automatic write_px(input int x, input int y, input logic [7:0] d);
        wr_valid_i = 1'b1;
        wr_x_i     = 8'(x);
        wr_y_i     = 7'(y);
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    // Count sampled cycles with busy high, bounded so a stuck FSM cannot hang the run.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy_o && n < 25000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset_ni      = 1'b0;
        row_i         = '0;
        column_i      = '0;
        wr_valid_i    = 1'b0;
        wr_x_i        = '0;
        wr_y_i        = '0;
        wr_data_i     = '0;
        clear_i       = 1'b0;
        clear_color_i = '0;
        pattern_i     = 1'b0;
        #1;
        check("rst_rgb", 32'(rgb_o), 32'h0000);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(wr_ready_o), 32'd1);
        check("rst_err", 32'(wr_err_o), 32'd0);
        #12 reset_ni = 1'b1;
        tick();

        // Bring the buffer to a known black state.
        clear_i       = 1'b1;
        clear_color_i = 8'h00;
        tick();
        clear_i = 1'b0;
        check("clr0_busy_rise", 32'(busy_o), 32'd1);
        wait_busy(cnt);
        check("clr0_len", 32'(cnt), 32'd19200);
        read_px("black_0_0", 0, 0, 16'h0000);

        // RGB332 -> RGB565 expansion and 4x4 scaling at pixel (0,0).
        write_px(0, 0, 8'hE0);
        check("err_inrange", 32'(wr_err_o), 32'd0);
        read_px("red_0_0", 0, 0, 16'hF800);
        read_px("red_3_3", 3, 3, 16'hF800);
        read_px("nbr_0_4", 0, 4, 16'h0000);
        read_px("nbr_4_0", 4, 0, 16'h0000);
        write_px(0, 0, 8'h1C);
        read_px("green_2_1", 2, 1, 16'h07E0);
        write_px(0, 0, 8'h03);
        read_px("blue_1_3", 1, 3, 16'h001F);
        write_px(0, 0, 8'hFF);
        read_px("white_3_0", 3, 0, 16'hFFFF);
        write_px(0, 0, 8'hA5);
        read_px("mixed_a5", 0, 2, 16'hB12A);

        // Far corner and out-of-range requests.
        write_px(159, 119, 8'hFF);
        read_px("corner_479_639", 479, 639, 16'hFFFF);
        read_px("corner_476_636", 476, 636, 16'hFFFF);
        read_px("row_480", 480, 0, 16'h0000);
        read_px("col_640", 0, 640, 16'h0000);
        read_px("row_511_col_1023", 511, 1023, 16'h0000);

        // Out-of-range write: accepted, flagged once, nothing stored (960 would alias pixel (0,6)).
        write_px(160, 5, 8'hFF);
        check("err_pulse", 32'(wr_err_o), 32'd1);
        tick();
        check("err_single", 32'(wr_err_o), 32'd0);
        read_px("oor_alias_0_6", 24, 0, 16'h0000);
        read_px("oor_0_5", 20, 0, 16'h0000);

        // Clear with a same-edge write, then a write held pending across the whole clear.
        wr_valid_i    = 1'b1;
        wr_x_i        = 8'd10;
        wr_y_i        = 7'd10;
        wr_data_i     = 8'hE0;
        clear_i       = 1'b1;
        clear_color_i = 8'h1C;
        tick();
        clear_i = 1'b0;
        wr_x_i  = 8'd20;
        wr_y_i  = 7'd20;
        check("clr1_busy_rise", 32'(busy_o), 32'd1);
        check("clr1_ready_low", 32'(wr_ready_o), 32'd0);
        wait_busy(cnt);
        check("clr1_len", 32'(cnt), 32'd19200);
        check("clr1_ready_back", 32'(wr_ready_o), 32'd1);
        tick();
        wr_valid_i = 1'b0;
        read_px("clr1_overwrite", 40, 40, 16'h07E0);
        read_px("clr1_stalled_wr", 80, 80, 16'hF800);
        read_px("clr1_0_0", 0, 0, 16'h07E0);
        read_px("clr1_mid", 240, 320, 16'h07E0);
        read_px("clr1_corner", 479, 639, 16'h07E0);

        // Reset part-way through a clear leaves the buffer partially filled.
        clear_i       = 1'b1;
        clear_color_i = 8'h03;
        tick();
        clear_i = 1'b0;
        repeat (4999) tick();
        check("clr2_busy_mid", 32'(busy_o), 32'd1);
        reset_ni = 1'b0;
        #1;
        check("clr2_rst_busy", 32'(busy_o), 32'd0);
        check("clr2_rst_ready", 32'(wr_ready_o), 32'd1);
        check("clr2_rst_rgb", 32'(rgb_o), 32'h0000);
        #10 reset_ni = 1'b1;
        tick();
        check("clr2_stays_idle", 32'(busy_o), 32'd0);
        read_px("clr2_done_0_0", 0, 0, 16'h001F);
        read_px("clr2_done_20_20", 80, 80, 16'h001F);
        read_px("clr2_untouched", 479, 639, 16'h07E0);

`ifdef VGA_PATTERN_EN
        pattern_i = 1'b1;
        read_px("pat_col0", 0, 0, 16'hFFFF);
        read_px("pat_col80", 10, 80, 16'hFFE0);
        read_px("pat_col400", 200, 400, 16'hF800);
        read_px("pat_col639", 479, 639, 16'h0000);
        read_px("pat_row480", 480, 100, 16'h0000);
        pattern_i = 1'b0;
        read_px("pat_off", 0, 0, 16'h001F);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_buffer.md
# vga_frame_buffer

Pixel source feeding the VGA driver's 16-bit RGB input. It holds a 160x120 frame buffer of RGB332 pixels, scaled 4x4 onto the 640x480 screen. It returns the RGB565 colour for the row and column the driver currently requests. A host write port stores individual pixels, and a clear engine fills the whole buffer with one colour.

## Interface
Parameters:
- `FB_W`, default 160: buffer width in pixels.
- `FB_H`, default 120: buffer height in pixels.
- `SCALE_LOG2`, default 2: screen pixels per buffer pixel, per axis, as log2.

Ports:
- `clk_i`  in  1  system clock; the same clock as the driver.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `row_i`  in  9  requested screen row, driven by the driver's row output.
- `column_i`  in  10  requested screen column, driven by the driver's column output.
- `rgb_o`  out  16  pixel colour {R[4:0], G[5:0], B[4:0]}, driving the driver's rgb input.
- `wr_valid_i`  in  1  host pixel write request.
- `wr_ready_o`  out  1  write port can accept a write.
- `wr_x_i`  in  8  buffer x coordinate.
- `wr_y_i`  in  7  buffer y coordinate.
- `wr_data_i`  in  8  RGB332 pixel {R[2:0], G[2:0], B[1:0]}.
- `wr_err_o`  out  1  one-cycle pulse when an accepted write had out-of-range coordinates.
- `clear_i`  in  1  start a clear; sampled only in IDLE.
- `clear_color_i`  in  8  RGB332 fill colour, sampled together with `clear_i`.
- `busy_o`  out  1  clear in progress.
- `pattern_i`  in  1  select the colour-bar test pattern (only with the macro in Configuration).

## Operation
- Storage: FB_W*FB_H = 19200 bytes in synchronous block RAM, one read port and one write port. Contents are not reset.
- Read address: `(row_i>>2)*160 + (column_i>>2)`, 15 bits. The multiply is implemented as `(y<<7)+(y<<5)`.
- Read range check: the request is in range only when `row_i < 480` and `column_i < 640`. Otherwise `rgb_o` is 0. Rows 480..511, which occur while the driver's row wraps during blanking, return black.
- RGB565 expansion:
  - R5 = {R3, R3[2:1]}
  - G6 = {G3, G3}
  - B5 = {B2, B2, B2[1]}
- Write handshake: a transfer occurs on the rising edge where `wr_valid_i && wr_ready_o`. `wr_ready_o` = (state == IDLE). The write port is blocked during a clear.
- Writes with `wr_x_i >= 160` or `wr_y_i >= 120` are accepted but not stored, and `wr_err_o` pulses on the following cycle.
- FSM states:
  - IDLE: on `clear_i` = 1, latch `clear_color_i`, set the clear address to 0 and go to CLEAR.
  - CLEAR: write the latched colour to the clear address, then increment it. After writing address 19199, return to IDLE. `clear_i` is ignored while in CLEAR.
- Simultaneous `clear_i` and an accepted write in IDLE: the write is stored on that edge and the clear starts, so the clear overwrites it.
- Reads continue normally during CLEAR. The display shows the fill progressing.
- Reset asserted mid-clear: the FSM goes to IDLE and `busy_o` drops. The buffer is left partially cleared.

## Timing
- Reset values:
  - `rgb_o` = 16'h0000
  - `busy_o` = 0
  - `wr_err_o` = 0
  - `wr_ready_o` = 1
  - FSM = IDLE
- Read latency: `rgb_o` reflects the `row_i`/`column_i` sampled at the previous rising edge, i.e. exactly 1 `clk_i` cycle. This is valid for any driver clock-enable ratio of 2 or more. The range flag is registered alongside the RAM read so both align.
- Clear duration: `busy_o` rises on the edge after `clear_i` is sampled and stays high for exactly 19200 cycles.
- Stored write visibility: a stored pixel is readable from the cycle after the write edge. The read-during-write result for the same address in the same cycle is old data.

## Configuration
- `VGA_PATTERN_EN`, defined: when `pattern_i` = 1 and the request is in range, `rgb_o` shows eight 80-column vertical bars in this order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Latency stays 1 cycle. The buffer and the write port keep operating.
- `VGA_PATTERN_EN`, undefined: `pattern_i` is ignored, no pattern logic is built, and output always comes from the buffer.

## Test plan
- Reset, then read any position -> `rgb_o` = 0000, `busy_o` = 0, `wr_ready_o` = 1.
- Write (x=0, y=0) with E0, 1C, 03 and FF in turn; read row 0..3, column 0..3 -> F800, 07E0, 001F, FFFF respectively, 1 cycle after each request.
- Write (159, 119) = FF; read (479, 639) -> FFFF. Read (480, 0) and (0, 640) -> 0000.
- Write (160, 5) = FF -> accepted, `wr_err_o` pulses once, buffer unchanged.
- `clear_i` with colour 1C -> `busy_o` high for 19200 cycles and `wr_valid_i` stalled; afterwards every position reads 07E0. Repeat with reset asserted at cycle 5000 -> `busy_o` = 0 immediately.
- With `VGA_PATTERN_EN` and `pattern_i` = 1: columns 0, 80, 400 and 639 -> FFFF, FFE0, F800, 0000.
